// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Shared definitions for the FIFO-fed UART transmitter:
//   state_e    - FSM state encoding (3-bit)
//   DATA_BITS  - data bits per frame, tied to the FIFO word width
//   TX_IDLE    - level of the serial line when no frame is in flight
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        TX_IDLE   = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; tick
// is high during the last cycle of each bit period.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous clear; holds the count at 0 while high
//   tick - one-cycle pulse in the final cycle of a bit period
// ---------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Masked by clr so no tick can leak out while the FSM holds the counter.
    assign tick = !clr && (cnt_q == CntMax);

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes from a registered-read FIFO and serialises each as an 8N1 UART
// frame (start bit, 8 data bits LSB first, stop bit).
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   en         - level enable; gates the start of new frames only
//   fifo_empty - FIFO empty flag, looked at only in IDLE
//   fifo_dout  - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en - one-cycle pop request
//   tx         - serial line, idle high
//   busy       - high in every state other than IDLE
//   tx_done    - one-cycle pulse in the last cycle of the stop bit
// All outputs decode registered state only; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = fifo_uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned IdxW    = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] LastBit = IdxW'(DATA_BITS - 1);

    state_e                state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
    logic                  baud_clr;
    logic                  tick;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        unique case (state_q)
            IDLE: begin
                // The only place fifo_empty and en are sampled.
                if (en && !fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                // Registered FIFO read data lands this cycle.
                shift_d   = fifo_dout;
                bit_idx_d = '0;
                state_d   = START;
            end
            START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + IdxW'(1);
                    if (bit_idx_q == LastBit) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        tx         = TX_IDLE;
        fifo_rd_en = 1'b0;
        busy       = (state_q != IDLE);
        tx_done    = 1'b0;
        baud_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_clr = 1'b1;
            end
            FETCH: begin
                baud_clr   = 1'b1;
                fifo_rd_en = 1'b1;
            end
            LOAD: begin
                baud_clr = 1'b1;
            end
            START: begin
                tx = 1'b0;
            end
            DATA: begin
                tx = shift_q[0];
            end
            STOP: begin
                tx_done = tick;
            end
            default: begin
                baud_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic       en;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: registered read, 16 deep. Writes from the stimulus process,
    // pops from the clocked process; each pointer has a single writer.
    logic [7:0] mem [16];
    int wr_ptr   = 0;
    int rd_ptr   = 0;
    int rd_pulse = 0;
    int bad_pop  = 0;
    int done_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    initial fifo_dout = 8'h00;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_pulse <= rd_pulse + 1;
            if (wr_ptr == rd_ptr) begin
                bad_pop <= bad_pop + 1;
            end else begin
                fifo_dout <= mem[rd_ptr % 16];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        if (tx_done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // line level per bit period, bit 0 sent first
    } vec_t;

    vec_t vecs [6];

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Step until tx goes low; gap counts the high cycles seen after entry.
    task automatic wait_start(output int gap, output bit ok);
        gap = 0;
        ok  = 1'b0;
        for (int n = 0; n < 300; n++) begin
            step();
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            gap++;
        end
        check("frame_start_seen", {31'd0, ok}, 32'd1);
    endtask

    // Current cycle is frame cycle 0; records the remaining frame cycles.
    task automatic collect(input int drop_en_at, output logic [FRAME-1:0] w,
                           output int done_at, output int done_hits);
        w         = '0;
        w[0]      = tx;
        done_at   = -1;
        done_hits = 0;
        if (tx_done) begin
            done_hits++;
            done_at = 0;
        end
        for (int k = 1; k < FRAME; k++) begin
            step();
            if (k == drop_en_at) en = 1'b0;
            w[k] = tx;
            if (tx_done) begin
                done_hits++;
                done_at = k;
            end
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [FRAME-1:0] w);
        logic [9:0] f;
        for (int i = 0; i < 10; i++) f[i] = w[i*CPB + 1];
        return f;
    endfunction

    function automatic bit uniform(input logic [FRAME-1:0] w);
        for (int i = 0; i < 10; i++)
            for (int j = 1; j < CPB; j++)
                if (w[i*CPB + j] !== w[i*CPB]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        logic [FRAME-1:0] wave;
        logic [FRAME-1:0] exp_wave;
        int               gap;
        int               done_at;
        int               done_hits;
        int               rd0;
        int               dn0;
        int               bad;
        bit               ok;

        vecs[0] = '{data: 8'hA5, frame: 10'h34A};
        vecs[1] = '{data: 8'h00, frame: 10'h200};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'h55, frame: 10'h2AA};
        vecs[4] = '{data: 8'h81, frame: 10'h302};
        vecs[5] = '{data: 8'h3C, frame: 10'h278};

        // Reset holds everything idle even with work available.
        rst = 1'b1;
        en  = 1'b1;
        push(8'hA5);
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_outputs", {28'd0, tx, busy, fifo_rd_en, tx_done}, 32'h8);
        end

        // Single byte 0xA5, cycle exact, including the 3-cycle latency.
        rst = 1'b0;
        step();
        check("fetch_rd_en", {29'd0, fifo_rd_en, busy, tx}, 32'h7);
        step();
        check("load_rd_en", {29'd0, fifo_rd_en, busy, tx}, 32'h3);
        step();
        check("start_tx_low", {31'd0, tx}, 32'd0);
        collect(-1, wave, done_at, done_hits);
        for (int k = 0; k < FRAME; k++) exp_wave[k] = vecs[0].frame[k / CPB];
        check("a5_wave", wave, exp_wave);
        check("a5_done_at", done_at, FRAME - 1);
        check("a5_done_hits", done_hits, 1);
        step();
        check("a5_after", {30'd0, busy, tx_done}, 32'd0);
        check("a5_rd_pulses", rd_pulse, 1);

        // Empty FIFO: nothing moves for 200 cycles.
        rd0 = rd_pulse;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        check("empty_idle_cycles_bad", bad, 0);
        check("empty_rd_pulses", rd_pulse - rd0, 0);

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            dn0 = done_cnt;
            push(vecs[v].data);
            wait_start(gap, ok);
            if (ok) begin
                collect(-1, wave, done_at, done_hits);
                check($sformatf("vec%0d_frame", v), frame_of(wave), vecs[v].frame);
                check($sformatf("vec%0d_uniform", v), uniform(wave), 1);
                check($sformatf("vec%0d_done_at", v), done_at, FRAME - 1);
                step();
                check($sformatf("vec%0d_done_cnt", v), done_cnt - dn0, 1);
            end
        end

        // Burst of 16 with minimum inter-frame gaps.
        en = 1'b0;
        step();
        for (int i = 0; i < 16; i++) push(i[7:0]);
        rd0 = rd_pulse;
        dn0 = done_cnt;
        en  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_start(gap, ok);
            if (!ok) break;
            if (i > 0) check($sformatf("burst%0d_gap", i), gap, 3);
            collect(-1, wave, done_at, done_hits);
            check($sformatf("burst%0d_frame", i), frame_of(wave), {1'b1, i[7:0], 1'b0});
        end
        step();
        check("burst_rd_pulses", rd_pulse - rd0, 16);
        check("burst_done_pulses", done_cnt - dn0, 16);
        check("burst_fifo_empty", {31'd0, fifo_empty}, 32'd1);

        // en drops during data bit 2 of the first of two queued bytes.
        rd0 = rd_pulse;
        push(8'hC3);
        push(8'h00);
        wait_start(gap, ok);
        if (ok) begin
            collect(3 * CPB + 1, wave, done_at, done_hits);
            check("endrop_frame", frame_of(wave), 10'h386);
            check("endrop_done_at", done_at, FRAME - 1);
        end
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("endrop_idle_bad", bad, 0);
        check("endrop_rd_pulses", rd_pulse - rd0, 1);
        check("endrop_fifo_not_empty", {31'd0, fifo_empty}, 32'd0);

        // Reset during data bit 3 of byte 0x00; next queued byte still goes out.
        en = 1'b1;
        wait_start(gap, ok);
        if (ok) begin
            for (int k = 1; k <= 4 * CPB + 1; k++) step();
            check("pre_reset_tx", {31'd0, tx}, 32'd0);
            dn0 = done_cnt;
            #2;
            rst = 1'b1;
            #1;
            check("reset_tx_immediate", {29'd0, tx, busy, tx_done}, 32'h4);
            push(8'h3C);
            for (int i = 0; i < 3; i++) step();
            check("reset_no_done", done_cnt - dn0, 0);
            rst = 1'b0;
            wait_start(gap, ok);
            if (ok) begin
                collect(-1, wave, done_at, done_hits);
                check("post_reset_frame", frame_of(wave), 10'h278);
                check("post_reset_done_hits", done_hits, 1);
            end
            step();
            check("post_reset_fifo_empty", {31'd0, fifo_empty}, 32'd1);
        end

        check("never_popped_empty", bad_pop, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
